// File: rtl/pyc_counter_pkg.sv
// -----------------------------------------------------------------------------
// pyc_counter_pkg
// Constants and types shared by the modulo counter and its next-value logic.
//   MODE_WRAP / MODE_SAT : values of the SAT parameter (wrap or saturate)
//   snap_state_t         : states of the snapshot valid/ready output stage
// -----------------------------------------------------------------------------
package pyc_counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    typedef enum logic {
        SNAP_EMPTY = 1'b0,
        SNAP_FULL  = 1'b1
    } snap_state_t;

endpackage

// File: rtl/pyc_counter_next.sv
// -----------------------------------------------------------------------------
// pyc_counter_next
// Purely combinational next-value arithmetic for a modulo (MAX+1) counter.
//   count      in  WIDTH  current count (always <= MAX)
//   up         in  1      1 = add step, 0 = subtract step
//   step       in  WIDTH  amount; values above MAX are treated as MAX
//   next_count out WIDTH  value after one enabled update
//   hit        out 1      the update wrapped (wrap mode) or clamped (sat mode)
// -----------------------------------------------------------------------------
module pyc_counter_next
    import pyc_counter_pkg::*;
#(
    parameter int              WIDTH = 8,
    parameter longint unsigned MAX   = (64'd1 << WIDTH) - 64'd1,
    parameter int              SAT   = MODE_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] next_count,
    output logic             hit
);

    localparam logic [WIDTH-1:0] MAX_W = MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    logic [WIDTH-1:0] step_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] wrap_up;
    logic [WIDTH-1:0] wrap_dn;

    assign step_eff = (step > MAX_W) ? MAX_W : step;

    // The extra bit keeps the carry so "sum > MAX" works even when MAX is all ones.
    assign sum = {1'b0, count} + {1'b0, step_eff};

    // Both wrapped results are known to lie in 0..MAX, so computing them modulo
    // 2**WIDTH gives the same answer as the (WIDTH+1)-bit "minus/plus (MAX+1)" form.
    assign wrap_up = sum[WIDTH-1:0] - MAX_W - ONE_W;
    assign wrap_dn = count + MAX_W + ONE_W - step_eff;

    // NOTE: every output of an always_comb gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_count = count;
        hit        = 1'b0;
        if (up) begin
            if (sum <= {1'b0, MAX_W}) begin
                next_count = sum[WIDTH-1:0];
            end else begin
                hit        = 1'b1;
                next_count = (SAT == MODE_SAT) ? MAX_W : wrap_up;
            end
        end else begin
            if (step_eff <= count) begin
                next_count = count - step_eff;
            end else begin
                hit        = 1'b1;
                next_count = (SAT == MODE_SAT) ? '0 : wrap_dn;
            end
        end
    end

endmodule

// File: rtl/pyc_modcounter.sv
// -----------------------------------------------------------------------------
// pyc_modcounter
// Up/down modulo (MAX+1) counter with clear, load, wrap/saturate overflow,
// a one-cycle terminal-count pulse and a one-deep snapshot output stage.
//   clk        in  1      clock, all state on rising edge
//   rst        in  1      asynchronous active-low reset
//   en         in  1      count enable
//   up         in  1      direction: 1 = up, 0 = down
//   step       in  WIDTH  increment/decrement amount
//   clr        in  1      synchronous clear to RESET_VAL (also clears snap_ovf)
//   load       in  1      synchronous load of min(load_val, MAX)
//   load_val   in  WIDTH  load value
//   count      out WIDTH  registered count
//   tc         out 1      pulse: previous en update wrapped or clamped
//   snap_req   in  1      capture the current count
//   snap_valid out 1      snapshot held
//   snap_ready in  1      consumer accepts the snapshot
//   snap_data  out WIDTH  captured count
//   snap_ovf   out 1      sticky: a request was dropped while full
// -----------------------------------------------------------------------------
module pyc_modcounter
    import pyc_counter_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter longint unsigned MAX       = (64'd1 << WIDTH) - 64'd1,
    parameter int              SAT       = MODE_WRAP,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] step,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    input  logic             snap_req,
    output logic             snap_valid,
    input  logic             snap_ready,
    output logic [WIDTH-1:0] snap_data,
    output logic             snap_ovf
);

    if (WIDTH < 1 || WIDTH > 32 || MAX < 1 ||
        MAX > ((64'd1 << WIDTH) - 64'd1) || RESET_VAL > MAX) begin : g_param_check
        $error("pyc_modcounter: illegal WIDTH/MAX/RESET_VAL combination");
    end

    localparam logic [WIDTH-1:0] MAX_W   = MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RESET_W = RESET_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic [WIDTH-1:0] next_count;
    logic             hit;
    logic [WIDTH-1:0] load_sat;

    pyc_counter_next #(
        .WIDTH (WIDTH),
        .MAX   (MAX),
        .SAT   (SAT)
    ) u_next (
        .count      (count_q),
        .up         (up),
        .step       (step),
        .next_count (next_count),
        .hit        (hit)
    );

    assign load_sat = (load_val > MAX_W) ? MAX_W : load_val;

    // NOTE: state is written with non-blocking assignments so every register
    // samples pre-edge values regardless of statement or process order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= RESET_W;
            tc_q    <= 1'b0;
        end else if (clr) begin
            count_q <= RESET_W;
            tc_q    <= 1'b0;
        end else if (load) begin
            count_q <= load_sat;
            tc_q    <= 1'b0;
        end else if (en) begin
            count_q <= next_count;
            tc_q    <= hit;
        end else begin
            tc_q    <= 1'b0;
        end
    end

    // ---------------- snapshot stage ----------------
    snap_state_t      state_q;
    snap_state_t      state_d;
    logic             capture;
    logic             drop;
    logic [WIDTH-1:0] snap_data_q;
    logic             snap_ovf_q;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        drop    = 1'b0;
        case (state_q)
            SNAP_EMPTY: begin
                if (snap_req) begin
                    capture = 1'b1;
                    state_d = SNAP_FULL;
                end
            end
            SNAP_FULL: begin
                if (snap_ready) begin
                    // Handshake frees the slot; a coincident request refills it.
                    if (snap_req) capture = 1'b1;
                    else          state_d = SNAP_EMPTY;
                end else if (snap_req) begin
                    drop = 1'b1;
                end
            end
            default: state_d = SNAP_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SNAP_EMPTY;
            snap_data_q <= '0;
            snap_ovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) snap_data_q <= count_q;   // pre-update count
            if (clr)       snap_ovf_q <= 1'b0;
            else if (drop) snap_ovf_q <= 1'b1;
        end
    end

    assign count      = count_q;
    assign tc         = tc_q;
    assign snap_valid = (state_q == SNAP_FULL);
    assign snap_data  = snap_data_q;
    assign snap_ovf   = snap_ovf_q;

endmodule

// File: tb/tb_pyc_modcounter.sv
// -----------------------------------------------------------------------------
// tb_pyc_modcounter
// Directed bench for pyc_modcounter with WIDTH=8, MAX=9, RESET_VAL=0.
// Two instances share all inputs: u_wrap (SAT=0) and u_sat (SAT=1).
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after the
// following rising edge.
// -----------------------------------------------------------------------------
module tb_pyc_modcounter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         up;
    logic [W-1:0] step;
    logic         clr;
    logic         load;
    logic [W-1:0] load_val;
    logic         snap_req;
    logic         snap_ready;

    logic [W-1:0] w_count, s_count;
    logic         w_tc, s_tc;
    logic         w_snap_valid, s_snap_valid;
    logic [W-1:0] w_snap_data, s_snap_data;
    logic         w_snap_ovf, s_snap_ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pyc_modcounter #(.WIDTH(W), .MAX(9), .SAT(0), .RESET_VAL(0)) u_wrap (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .up         (up),
        .step       (step),
        .clr        (clr),
        .load       (load),
        .load_val   (load_val),
        .count      (w_count),
        .tc         (w_tc),
        .snap_req   (snap_req),
        .snap_valid (w_snap_valid),
        .snap_ready (snap_ready),
        .snap_data  (w_snap_data),
        .snap_ovf   (w_snap_ovf)
    );

    pyc_modcounter #(.WIDTH(W), .MAX(9), .SAT(1), .RESET_VAL(0)) u_sat (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .up         (up),
        .step       (step),
        .clr        (clr),
        .load       (load),
        .load_val   (load_val),
        .count      (s_count),
        .tc         (s_tc),
        .snap_req   (snap_req),
        .snap_valid (s_snap_valid),
        .snap_ready (snap_ready),
        .snap_data  (s_snap_data),
        .snap_ovf   (s_snap_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1'b0; up = 1'b1; step = 8'd1; clr = 1'b0; load = 1'b0;
        load_val = 8'd0; snap_req = 1'b0; snap_ready = 1'b0;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1; load_val = v;
        tick();
        load = 1'b0;
    endtask

    initial begin
        logic [W-1:0] exp_cnt;

        // ---------------- reset ----------------
        idle();
        rst = 1'b0;
        #2;
        check("rst_count",  w_count, 0);
        check("rst_tc",     w_tc, 0);
        check("rst_valid",  w_snap_valid, 0);
        check("rst_data",   w_snap_data, 0);
        check("rst_ovf",    w_snap_ovf, 0);
        tick();
        tick();
        rst = 1'b1;

        // ---------------- wrap count up by 1 ----------------
        en = 1'b1; up = 1'b1; step = 8'd1;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_cnt = 8'((i + 1) % 10);
            check($sformatf("up1_count[%0d]", i), w_count, exp_cnt);
            check($sformatf("up1_tc[%0d]", i), w_tc, (exp_cnt == 0) ? 1 : 0);
        end
        idle();

        // ---------------- saturate up by 3 from 8 ----------------
        do_load(8'd8);
        check("sat_load8", s_count, 8);
        check("sat_load8_tc", s_tc, 0);
        en = 1'b1; up = 1'b1; step = 8'd3;
        tick();
        check("sat_up3_a", s_count, 9);
        check("sat_up3_a_tc", s_tc, 1);
        check("wrap_up3_a", w_count, 1);
        check("wrap_up3_a_tc", w_tc, 1);
        tick();
        check("sat_up3_b", s_count, 9);
        check("sat_up3_b_tc", s_tc, 1);
        check("wrap_up3_b", w_count, 4);
        check("wrap_up3_b_tc", w_tc, 0);
        idle();

        // ---------------- down count, step clamping ----------------
        do_load(8'd1);
        en = 1'b1; up = 1'b0; step = 8'd2;
        tick();
        check("wrap_dn2", w_count, 9);
        check("wrap_dn2_tc", w_tc, 1);
        check("sat_dn2", s_count, 0);
        check("sat_dn2_tc", s_tc, 1);
        step = 8'd12;   // treated as 9
        tick();
        check("wrap_dn12", w_count, 0);
        check("wrap_dn12_tc", w_tc, 0);
        check("sat_dn12", s_count, 0);
        check("sat_dn12_tc", s_tc, 1);
        idle();

        // ---------------- priority, load clamp, step 0 ----------------
        clr = 1'b1; load = 1'b1; load_val = 8'd7; en = 1'b1; up = 1'b1; step = 8'd1;
        do_load(8'd7);
        check("prio_count", w_count, 0);
        check("prio_tc", w_tc, 0);
        idle();
        do_load(8'd200);
        check("load200", w_count, 9);
        check("load200_tc", w_tc, 0);
        en = 1'b1; up = 1'b1; step = 8'd0;
        tick();
        check("step0_count", w_count, 9);
        check("step0_tc", w_tc, 0);
        idle();

        // ---------------- snapshot ----------------
        do_load(8'd5);
        en = 1'b1; up = 1'b1; step = 8'd1; snap_req = 1'b1; snap_ready = 1'b0;
        tick();
        check("snap1_count", w_count, 6);
        check("snap1_valid", w_snap_valid, 1);
        check("snap1_data", w_snap_data, 5);
        check("snap1_ovf", w_snap_ovf, 0);
        tick();
        check("snap2_count", w_count, 7);
        check("snap2_ovf", w_snap_ovf, 1);
        check("snap2_data", w_snap_data, 5);
        check("snap2_valid", w_snap_valid, 1);
        en = 1'b0; snap_ready = 1'b1;
        tick();
        check("snap3_valid", w_snap_valid, 1);
        check("snap3_data", w_snap_data, 7);
        check("snap3_ovf", w_snap_ovf, 1);
        snap_req = 1'b0; snap_ready = 1'b0; clr = 1'b1;
        tick();
        check("clr_ovf", w_snap_ovf, 0);
        check("clr_valid", w_snap_valid, 1);
        check("clr_data", w_snap_data, 7);
        check("clr_count", w_count, 0);
        clr = 1'b0;
        do_load(8'd7);
        check("pre_rst_count", w_count, 7);
        check("pre_rst_valid", w_snap_valid, 1);

        // ---------------- asynchronous reset mid-handshake ----------------
        en = 1'b1; snap_ready = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("arst_count", w_count, 0);
        check("arst_valid", w_snap_valid, 0);
        check("arst_data", w_snap_data, 0);
        check("arst_ovf", w_snap_ovf, 0);
        tick();
        idle();
        rst = 1'b1;

        // ---------------- handshake without request empties ----------------
        snap_req = 1'b1;
        tick();
        check("hs_fill_valid", w_snap_valid, 1);
        check("hs_fill_data", w_snap_data, 0);
        snap_req = 1'b0; snap_ready = 1'b1;
        tick();
        check("hs_empty_valid", w_snap_valid, 0);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pyc_modcounter.md
PYC_MODCOUNTER -- requirements
Module: pyc_modcounter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning count width in bits (1..32).
REQ-002 SHALL have parameter MAX, default 2**WIDTH-1, meaning terminal count, so the modulus is MAX+1; legal range 1..2**WIDTH-1.
REQ-003 SHALL have parameter SAT, default 0, meaning overflow mode: 0 = wrap, 1 = saturate.
REQ-004 SHALL have parameter RESET_VAL, default 0, meaning reset/clear value; must be <= MAX.
REQ-005 SHALL have port clk  in  1  sole clock, all state rising-edge.
REQ-006 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-007 SHALL have port en  in  1  count enable.
REQ-008 SHALL have port up  in  1  direction: 1 = up, 0 = down.
REQ-009 SHALL have port step  in  WIDTH  increment/decrement amount.
REQ-010 SHALL have port clr  in  1  synchronous clear to RESET_VAL.
REQ-011 SHALL have port load  in  1  synchronous load.
REQ-012 SHALL have port load_val  in  WIDTH  load value.
REQ-013 SHALL have port count  out  WIDTH  registered count.
REQ-014 SHALL have port tc  out  1  registered one-cycle terminal-count pulse.
REQ-015 SHALL have ports snap_req  in  1, snap_valid  out  1, snap_ready  in  1, snap_data  out  WIDTH, and snap_ovf  out  1, forming the snapshot request and valid/ready output.

Function
REQ-016 count SHALL update one cycle after the controlling edge (latency 1), with priority clr > load > en; with none active it holds.
REQ-017 load SHALL set count to min(load_val, MAX); tc SHALL stay 0 for clr and load cycles.
REQ-018 A step value greater than MAX SHALL be treated as MAX; step = 0 with en SHALL leave count unchanged and SHALL NOT pulse tc.
REQ-019 Up-count SHALL compute s = count+step in WIDTH+1 bits; if s <= MAX the result is s; otherwise wrap mode gives s-(MAX+1) and saturate mode gives MAX.
REQ-020 Down-count with step <= count SHALL give count-step; otherwise wrap mode gives count+(MAX+1)-step and saturate mode gives 0.
REQ-021 tc SHALL be 1 for exactly the cycle after any en update that wrapped or clamped; in saturate mode this includes repeated clamping while the count sits at its limit.
REQ-022 The snapshot SHALL use a 2-state machine, EMPTY/FULL, and snap_valid SHALL equal (state == FULL).
REQ-023 snap_req in EMPTY SHALL capture the pre-update count into snap_data and go to FULL.
REQ-024 In FULL, snap_valid && snap_ready without snap_req SHALL return the machine to EMPTY.
REQ-025 In FULL, a handshake coinciding with snap_req SHALL capture the new count and remain FULL.
REQ-026 In FULL, snap_req without snap_ready SHALL be dropped, SHALL leave snap_data unchanged, and SHALL set snap_ovf sticky.
REQ-027 snap_data SHALL remain stable while snap_valid=1 and snap_ready=0.
REQ-028 clr SHALL also clear snap_ovf but SHALL NOT disturb a pending snapshot.

Reset
REQ-029 Asserting rst low SHALL immediately and asynchronously force count=RESET_VAL, tc=0, snap_valid=0 (state EMPTY), snap_data=0 and snap_ovf=0, including mid-count and mid-handshake.
REQ-030 Deassertion SHALL be synchronised externally; the first counting edge is the first rising clk with rst high.

Structure
REQ-031 Shared package pyc_counter_pkg SHALL hold the mode constants (MODE_WRAP=0, MODE_SAT=1) and the snapshot state enum (SNAP_EMPTY, SNAP_FULL).
REQ-032 Next-value arithmetic (REQ-018 to REQ-021) SHALL be a combinational sub-module pyc_counter_next producing next_count and hit; count and tc SHALL be plain registers in pyc_modcounter.
REQ-033 Elaboration SHALL fail if MAX > 2**WIDTH-1 or RESET_VAL > MAX.

Verification (WIDTH=8, MAX=9, RESET_VAL=0 unless noted)
REQ-034 Bench SHALL check: reset, en=1, up=1, step=1 for 12 cycles -> count 1..9,0,1,2; tc=1 only in the cycle count shows 0.
REQ-035 Bench SHALL check: SAT=1, load 8, then en up step=3 for 2 cycles -> count 9, 9; tc=1 both cycles.
REQ-036 Bench SHALL check: wrap, load 1, up=0, step=2, one en cycle -> count 9, tc=1; step=12 from 9 -> treated as 9 -> count 0, tc=0.
REQ-037 Bench SHALL check: clr=1, load=1 (load_val 7), en=1 in the same cycle -> count 0, tc=0; load_val 200 alone -> count 9.
REQ-038 Bench SHALL check: count=5, snap_req, snap_ready=0 -> snap_valid=1, snap_data=5; snap_req again at count 6 -> snap_ovf=1, data 5; snap_ready=1 with snap_req at count 7 -> valid stays 1, data 7; clr -> snap_ovf=0.
REQ-039 Bench SHALL check: rst low between edges at count 7 with snap_valid=1 -> count=0 and snap_valid=0 before the next clk edge.
